decimator_stream: RTL and testbench
===================================

DECIMATOR_STREAM -- requirements
Module: decimator_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16: input/output sample width, two's complement.
REQ-002 SHALL have parameter MAX_FACTOR, default 16: largest decimation factor accepted; power of two, 2..256.
REQ-003 SHALL have parameter FW, default $clog2(MAX_FACTOR)+1: width of the factor/phase config ports.
REQ-004 SHALL have port clk  input  1: the only clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n  input  1: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port enable  input  1: level; 1 = run, 0 = return to IDLE.
REQ-007 SHALL have port mode  input  1: 0 = pick (keep one sample per block), 1 = average (boxcar mean per block).
REQ-008 SHALL have port factor  input  FW: decimation factor M, sampled only on the IDLE->RUN transition.
REQ-009 SHALL have port phase  input  FW: pick-mode index 0..M-1 within a block, sampled with factor.
REQ-010 SHALL have port in_valid  input  1: in_data qualifier; only valid samples are counted.
REQ-011 SHALL have port in_data  input  DATA_W: signed input sample.
REQ-012 SHALL have port out_valid  output  1: single-cycle pulse per completed block.
REQ-013 SHALL have port out_data  output  DATA_W: decimated sample; holds its value between pulses.
REQ-014 SHALL have port cfg_err  output  1: sticky flag set on a rejected configuration.

Function
REQ-015 SHALL implement FSM IDLE, RUN; reset and enable=0 force IDLE.
REQ-016 IDLE->RUN SHALL occur when enable=1 and config is legal; M, phase, mode and SHIFT=log2(M) are latched into internal registers on that edge.
REQ-017 Legal config: 1<=M<=MAX_FACTOR; phase<M; in mode 1, M a power of two.
REQ-018 Illegal config with enable=1 in IDLE SHALL set cfg_err and remain IDLE; cfg_err is cleared only by reset or by a legal IDLE->RUN transition.
REQ-019 Config port changes while in RUN SHALL be ignored.
REQ-020 In RUN, the sample counter cnt (0..M-1) SHALL advance only on cycles with in_valid=1, wrapping M-1->0; idle cycles are never counted.
REQ-021 Pick mode: the sample with cnt==phase SHALL be captured; out_valid pulses and out_data updates in the cycle after the sample with cnt==M-1 is accepted.
REQ-022 Average mode: the accumulator, width DATA_W+log2(MAX_FACTOR), SHALL sign-extend and sum M valid samples; on the M-th sample the result is out_data = sum arithmetically shifted right by SHIFT (floor), and the accumulator reloads without a dead cycle.
REQ-023 Latency SHALL be 1 clock from acceptance of the last sample of a block to out_valid=1.
REQ-024 M=1 SHALL give passthrough: out_valid = in_valid delayed 1 cycle, out_data = in_data delayed 1 cycle, in both modes.
REQ-025 Back-to-back in_valid SHALL sustain one output every M input cycles, no stalls.
REQ-026 enable deasserted mid-block SHALL discard the partial block (no out_valid) and enter IDLE next cycle; an output already due that cycle is still emitted.
REQ-027 The block SHALL have no backpressure; out_valid is never held longer than 1 cycle.

Reset
REQ-028 On reset_n=0 at a clock edge: state=IDLE, cnt=0, accumulator=0, out_valid=0, out_data=0, cfg_err=0, latched config: M=1, phase=0, mode=0.
REQ-029 reset_n=0 mid-block SHALL discard the partial block without emitting out_valid.

Verification
REQ-030 Pick: M=6, phase=0, mode=0, in_valid=1 continuously, in_data=0,1,2,... -> out_data 0,6,12,... pulses every 6 cycles, each 1 cycle after samples 5,11,17.
REQ-031 Average: M=4, mode=1, samples 4,8,-4,1 -> out_data=2 (9>>2); samples -1,-1,-1,-2 -> out_data=-2 (floor of -5/4).
REQ-032 Gapped input: M=3, phase=2, in_valid pattern 1,0,0,1,1,0,1 on data 10..16 -> single output 14, in the cycle after in_data=14.
REQ-033 Illegal config: mode=1, M=6, enable=1 -> cfg_err=1, stays IDLE, no out_valid; then M=4 -> RUN entered, cfg_err=0.
REQ-034 Abort: M=8, enable dropped after 5 samples -> no out_valid; re-enable with M=2 -> first output after 2 new samples.
REQ-035 Reset mid-block and M=1 passthrough: reset_n=0 after 3 of M=4 samples -> all outputs 0 next cycle, no out_valid; M=1 -> out_data follows in_data delayed one cycle, with out_valid following in_valid one cycle later.

Source files
------------

// File: rtl/decimator_stream_if.sv
// Sample stream bundle for decimator_stream: the input samples in,
// the decimated samples out.
interface decimator_stream_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/decimator_stream.sv
// Streaming decimator by M: keeps one chosen sample per block (pick)
// or emits the floor mean of each block (average, M a power of two).
module decimator_stream #(
    parameter int DATA_W     = 16,
    parameter int MAX_FACTOR = 16,
    parameter int FW         = $clog2(MAX_FACTOR) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              mode,
    input  logic [FW-1:0]     factor,
    input  logic [FW-1:0]     phase,
    output logic              cfg_err,
    decimator_stream_if.slave stream
);
    localparam int AW = DATA_W + $clog2(MAX_FACTOR);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 start;
    logic                 accept;
    logic                 legal;
    logic                 pow2;
    logic                 last;
    logic [FW-1:0]        shift_calc;
    logic [FW-1:0]        m_reg;
    logic [FW-1:0]        phase_reg;
    logic [FW-1:0]        shift_reg;
    logic                 mode_reg;
    logic [FW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [DATA_W-1:0]    capture;
    logic [DATA_W-1:0]    pick_out;
    logic [DATA_W-1:0]    avg_out;

    // Config legality and log2 of the factor, evaluated on the raw ports
    always_comb begin
        pow2       = (factor & (factor - FW'(1))) == '0;
        legal      = (factor != '0) && (factor <= FW'(MAX_FACTOR)) &&
                     (phase < factor) && (!mode || pow2);
        shift_calc = '0;
        for (int i = 0; i < FW; i++) begin
            if (factor[i]) begin
                shift_calc = FW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A sample is only taken while running with enable still high
    always_comb begin
        state_next = state;
        start      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && legal) begin
                    state_next = RUN;
                    start      = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    accept = stream.in_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last     = (cnt == m_reg - FW'(1));
        sum      = acc + {{(AW-DATA_W){stream.in_data[DATA_W-1]}}, stream.in_data};
        avg_out  = DATA_W'(sum >>> shift_reg);
        pick_out = (cnt == phase_reg) ? stream.in_data : capture;
    end

    // The accumulator restarts from zero on the closing sample, so the next
    // block's first sample is summed without a gap
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_reg            <= FW'(1);
            phase_reg        <= '0;
            shift_reg        <= '0;
            mode_reg         <= 1'b0;
            cnt              <= '0;
            acc              <= '0;
            capture          <= '0;
            cfg_err          <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
        end else begin
            stream.out_valid <= 1'b0;
            if (state == IDLE && enable) begin
                cfg_err <= !legal;
            end
            if (start) begin
                m_reg     <= factor;
                phase_reg <= phase;
                mode_reg  <= mode;
                shift_reg <= shift_calc;
                cnt       <= '0;
                acc       <= '0;
            end
            if (accept) begin
                if (cnt == phase_reg) begin
                    capture <= stream.in_data;
                end
                if (last) begin
                    cnt              <= '0;
                    acc              <= '0;
                    stream.out_valid <= 1'b1;
                    stream.out_data  <= mode_reg ? avg_out : pick_out;
                end else begin
                    cnt <= cnt + FW'(1);
                    acc <= sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_decimator_stream.sv
// Bench for decimator_stream: directed cases with literal expectations plus
// randomized traffic compared every cycle against a block-level model.
module tb_decimator_stream;
    localparam int DATA_W     = 16;
    localparam int MAX_FACTOR = 16;
    localparam int FW         = $clog2(MAX_FACTOR) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          mode = 1'b0;
    logic [FW-1:0] factor = FW'(1);
    logic [FW-1:0] phase = '0;
    logic          cfg_err;

    decimator_stream_if #(.DATA_W(DATA_W)) sif();

    decimator_stream #(
        .DATA_W(DATA_W),
        .MAX_FACTOR(MAX_FACTOR),
        .FW(FW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .mode(mode),
        .factor(factor),
        .phase(phase),
        .cfg_err(cfg_err),
        .stream(sif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    bit mRun = 1'b0;
    bit mErr = 1'b0;
    bit mValid = 1'b0;
    bit mMode = 1'b0;
    int mM = 1;
    int mPhase = 0;
    int mData = 0;
    int block[$];

    function automatic bit legalCfg(input int f, input int p, input bit md);
        bit pw = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (f == (1 << k)) pw = 1'b1;
        end
        return (f >= 1) && (f <= MAX_FACTOR) && (p < f) && (!md || pw);
    endfunction

    // Average is the mathematical floor of the mean, not a shift
    function automatic int blockResult();
        int s = 0;
        int q;
        if (!mMode) return block[mPhase];
        foreach (block[i]) s += block[i];
        q = s / mM;
        if ((s % mM) != 0 && s < 0) q -= 1;
        return q;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            mRun   = 1'b0;
            mErr   = 1'b0;
            mValid = 1'b0;
            mData  = 0;
            mM     = 1;
            mPhase = 0;
            mMode  = 1'b0;
            block.delete();
        end else begin
            mValid = 1'b0;
            if (!mRun) begin
                if (enable) begin
                    if (legalCfg(int'(factor), int'(phase), mode)) begin
                        mRun   = 1'b1;
                        mErr   = 1'b0;
                        mM     = int'(factor);
                        mPhase = int'(phase);
                        mMode  = mode;
                        block.delete();
                    end else begin
                        mErr = 1'b1;
                    end
                end
            end else if (!enable) begin
                mRun = 1'b0;
                block.delete();
            end else if (sif.in_valid) begin
                block.push_back(int'($signed(sif.in_data)));
                if (block.size() == mM) begin
                    mValid = 1'b1;
                    mData  = blockResult();
                    block.delete();
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("out_valid", int'(sif.out_valid), int'(mValid));
            checkOutput("out_data", int'($signed(sif.out_data)), mData);
            checkOutput("cfg_err", int'(cfg_err), int'(mErr));
        end
    end

    task automatic applyStimulus(input bit iv, input int d);
        sif.in_valid = iv;
        sif.in_data  = DATA_W'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic startRun(input int f, input int p, input bit md);
        enable       = 1'b0;
        sif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        factor = FW'(f);
        phase  = FW'(p);
        mode   = md;
        enable = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int qAt(input int q[$], input int k);
        return (q.size() > k) ? q[k] : -9999;
    endfunction

    initial begin
        int got[$];
        int at[$];
        int pulses;
        bit pat[7];
        bit iv;
        int d;
        int f;
        int p;
        int n;

        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        checkOutput("reset_valid", int'(sif.out_valid), 0);
        checkOutput("reset_data", int'(sif.out_data), 0);
        checkOutput("reset_err", int'(cfg_err), 0);
        reset_n = 1'b1;

        $display("[TB] pick M=6 phase=0");
        startRun(6, 0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, i);
            if (sif.out_valid) begin
                got.push_back(int'($signed(sif.out_data)));
                at.push_back(i);
            end
        end
        checkOutput("pick_count", got.size(), 3);
        checkOutput("pick_val0", qAt(got, 0), 0);
        checkOutput("pick_val1", qAt(got, 1), 6);
        checkOutput("pick_val2", qAt(got, 2), 12);
        checkOutput("pick_at0", qAt(at, 0), 5);
        checkOutput("pick_at2", qAt(at, 2), 17);

        $display("[TB] average M=4");
        startRun(4, 0, 1'b1);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b1, 8);
        applyStimulus(1'b1, -4);
        applyStimulus(1'b1, 1);
        checkOutput("avg_pos_valid", int'(sif.out_valid), 1);
        checkOutput("avg_pos_data", int'($signed(sif.out_data)), 2);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -2);
        checkOutput("avg_neg_valid", int'(sif.out_valid), 1);
        checkOutput("avg_neg_data", int'($signed(sif.out_data)), -2);

        $display("[TB] gapped input M=3 phase=2");
        startRun(3, 2, 1'b0);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        got.delete();
        at.delete();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(pat[i], 10 + i);
            if (sif.out_valid) begin
                got.push_back(int'($signed(sif.out_data)));
                at.push_back(i);
            end
        end
        checkOutput("gap_count", got.size(), 1);
        checkOutput("gap_val", qAt(got, 0), 14);
        checkOutput("gap_at", qAt(at, 0), 4);

        $display("[TB] illegal config");
        startRun(6, 0, 1'b1);
        checkOutput("illegal_err", int'(cfg_err), 1);
        applyStimulus(1'b1, 5);
        applyStimulus(1'b1, 6);
        checkOutput("illegal_novalid", int'(sif.out_valid), 0);
        factor = FW'(4);
        applyStimulus(1'b0, 0);
        checkOutput("legal_clear", int'(cfg_err), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2);
        checkOutput("legal_run_valid", int'(sif.out_valid), 1);
        checkOutput("legal_run_data", int'($signed(sif.out_data)), 2);

        $display("[TB] abort mid-block");
        startRun(8, 0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 20 + i);
            pulses += int'(sif.out_valid);
        end
        enable = 1'b0;
        applyStimulus(1'b1, 99);
        pulses += int'(sif.out_valid);
        checkOutput("abort_pulses", pulses, 0);
        startRun(2, 1, 1'b0);
        applyStimulus(1'b1, 30);
        checkOutput("reen_first", int'(sif.out_valid), 0);
        applyStimulus(1'b1, 31);
        checkOutput("reen_valid", int'(sif.out_valid), 1);
        checkOutput("reen_data", int'($signed(sif.out_data)), 31);

        $display("[TB] reset mid-block and passthrough");
        startRun(4, 0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 7);
        reset_n = 1'b0;
        applyStimulus(1'b1, 7);
        checkOutput("rst_valid", int'(sif.out_valid), 0);
        checkOutput("rst_data", int'(sif.out_data), 0);
        reset_n = 1'b1;
        for (int md = 0; md < 2; md++) begin
            startRun(1, 0, md[0]);
            for (int i = 0; i < 12; i++) begin
                iv = 1'($urandom_range(0, 1));
                d  = int'($signed(DATA_W'($urandom)));
                applyStimulus(iv, d);
                checkOutput("pass_valid", int'(sif.out_valid), int'(iv));
                if (iv) checkOutput("pass_data", int'($signed(sif.out_data)), d);
            end
        end

        $display("[TB] randomized traffic");
        for (int blk = 0; blk < 30; blk++) begin
            f = $urandom_range(0, MAX_FACTOR + 1);
            p = $urandom_range(0, (f > 0) ? f : 0);
            startRun(f, p, 1'($urandom_range(0, 1)));
            n = $urandom_range(20, 60);
            for (int c = 0; c < n; c++) begin
                reset_n = ($urandom_range(0, 49) != 0);
                enable  = ($urandom_range(0, 39) != 0);
                if ($urandom_range(0, 9) == 0) begin
                    factor = FW'($urandom_range(1, MAX_FACTOR));
                    phase  = FW'($urandom_range(0, 3));
                    mode   = 1'($urandom_range(0, 1));
                end
                applyStimulus(($urandom_range(0, 3) != 0), int'($signed(DATA_W'($urandom))));
            end
            reset_n = 1'b1;
        end

        sif.in_valid = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
